hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the five-stage MIPS core. Each cycle it decides which pipeline registers and the PC advance, freeze, or are flushed. Its inputs are instruction/data memory handshakes, load-use hazards that forwarding cannot cover, taken branches, jumps and halt. It sits beside the forwarding unit and drives the enable/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC.

## Interface
Parameters:
- REGW, 5, register index width

Ports:
- CLK  in  1  core clock, rising edge
- RST  in  1  synchronous reset, active-high
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- dmem_req_mem  in  1  MEM-stage instruction reads or writes memory
- lw_ex  in  1  ID/EX holds LW
- wsel_ex  in  REGW  destination register of ID/EX
- rs_id, rt_id  in  REGW  source registers of IF/ID
- uses_rt_id  in  1  IF/ID instruction reads rt as a source
- branch_taken_ex  in  1  branch in EX resolved taken
- jump_id  in  1  IF/ID holds J/JAL/JR
- halt_mem  in  1  EX/MEM holds HALT
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  register enables
- ifid_flush, idex_flush  out  1  load bubble into register (valid only with its enable)
- dmem_mask  out  1  suppress dREN/dWEN to memory controller
- halted  out  1  core halted
- stall_cnt, flush_cnt  out  32  performance counters (only with HAZARD_PERF_CNT_EN)

## Operation
- FSM states: RUN, DRAIN, HALT. Reset → RUN. No other transitions besides those listed.
- advance = ihit & ~(dmem_req_mem & ~dmem_mask & ~dhit).
- In RUN, evaluated in priority order:
  1. ~advance: all enables 0, flushes 0.
  2. halt_mem: memwb_en=1, other enables 0; next DRAIN.
  3. branch_taken_ex: all enables 1, ifid_flush=1, idex_flush=1; flush_cnt+1.
  4. Load-use: lw_ex & wsel_ex≠0 & (wsel_ex==rs_id | (uses_rt_id & wsel_ex==rt_id)).
     - pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1, exmem_en=1, memwb_en=1.
  5. jump_id: all enables 1, ifid_flush=1.
  6. Otherwise: all enables 1, flushes 0.
- DRAIN: all enables 0, WB commits the HALT; next HALT.
- HALT: all enables 0, halted=1; leaves only on RST.
- dmem_mask register:
  - Set when dhit=1 & dmem_req_mem=1 & ~ihit, so the data access completed but the pipe is frozen.
  - Cleared on any cycle with exmem_en=1.
  - Keeps a completed load/store from being reissued.
- stall_cnt increments on every RUN cycle with pc_en=0, excluding the halt cycle.

## Timing
- All outputs are combinational from current state, dmem_mask and current inputs: zero-cycle latency.
- State, dmem_mask and counters update on rising CLK.
- While RST=1: all enables 0, flushes 0, dmem_mask 0, halted 0.
- The cycle after RST deasserts: state RUN, counters 0.
- RST mid-DRAIN/HALT returns the FSM to RUN on the next edge.
- Load-use stall lasts exactly one cycle: LW moves to MEM and the condition clears.
- Taken branch costs two bubbles. Jump costs one.
- Simultaneous dhit & ihit: advance; dmem_mask stays 0.
- Counters wrap modulo 2^32.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cnt/flush_cnt ports and registers exist as described.
- Undefined: ports are absent and no counter logic is built. Pipeline behaviour is identical.

## Test plan
- Reset, then ihit=1 with no hazards → all enables 1, flushes 0, halted 0 every cycle.
- lw_ex=1, wsel_ex=8, rs_id=8, ihit=1 → one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1; stall_cnt=1.
- dmem_req_mem=1, dhit=1, ihit=0 for 3 cycles, then ihit=1:
  - dmem_mask=1 during the frozen cycles after dhit.
  - Enables all 1 on the ihit cycle.
  - dmem_mask=0 afterward.
- branch_taken_ex=1 and jump_id=1 together → ifid_flush=1, idex_flush=1, flush_cnt=1.
- halt_mem=1 with advance → memwb_en only, then DRAIN (all 0), then halted=1. Assert RST → halted=0, state RUN next cycle.
- lw_ex=1, wsel_ex=0, rs_id=0 → no stall.

Source files
------------

// File: rtl/hazard_if.sv
// Pipeline-to-hazard-controller bundle: hazard inputs from the datapath and
// the stage enables/flushes, memory mask and halt status back to it.
interface hazard_if #(
    parameter int REGW = 5
);
    logic            ihit;
    logic            dhit;
    logic            dmem_req_mem;
    logic            lw_ex;
    logic [REGW-1:0] wsel_ex;
    logic [REGW-1:0] rs_id;
    logic [REGW-1:0] rt_id;
    logic            uses_rt_id;
    logic            branch_taken_ex;
    logic            jump_id;
    logic            halt_mem;

    logic            pc_en;
    logic            ifid_en;
    logic            idex_en;
    logic            exmem_en;
    logic            memwb_en;
    logic            ifid_flush;
    logic            idex_flush;
    logic            dmem_mask;
    logic            halted;

    modport master (
        output ihit, dhit, dmem_req_mem, lw_ex, wsel_ex, rs_id, rt_id,
               uses_rt_id, branch_taken_ex, jump_id, halt_mem,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, dmem_mask, halted
    );

    modport slave (
        input  ihit, dhit, dmem_req_mem, lw_ex, wsel_ex, rs_id, rt_id,
               uses_rt_id, branch_taken_ex, jump_id, halt_mem,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, dmem_mask, halted
    );
endinterface

// File: rtl/hazard_controller.sv
// Five-stage MIPS pipeline sequencer: stage enables/flushes, memory reissue mask, halt FSM.
// Optional HAZARD_PERF_CNT_EN adds stall/flush performance counters.
module hazard_controller #(
    parameter int REGW = 5
) (
    input  logic        CLK,
    input  logic        RST,
    hazard_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);
    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

    state_e state_q, state_d;
    logic   dmem_mask_q, dmem_mask_d;

    logic advance, load_use;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush;

    // A masked access has already completed, so it no longer holds the pipe.
    assign advance  = hz.ihit & ~(hz.dmem_req_mem & ~dmem_mask_q & ~hz.dhit);
    assign load_use = hz.lw_ex && (hz.wsel_ex != REGW'(0)) &&
                      ((hz.wsel_ex == hz.rs_id) || (hz.uses_rt_id && (hz.wsel_ex == hz.rt_id)));

    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        unique case (state_q)
            RUN: begin
                if (!advance) begin
                    // frozen: everything holds
                end else if (hz.halt_mem) begin
                    memwb_en = 1'b1;
                    state_d  = DRAIN;
                end else if (hz.branch_taken_ex) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    {idex_en, exmem_en, memwb_en} = 3'b111;
                    idex_flush = 1'b1;
                end else if (hz.jump_id) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                    ifid_flush = 1'b1;
                end else begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                end
            end
            DRAIN:   state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
        if (RST) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
        end
    end

    always_comb begin
        dmem_mask_d = dmem_mask_q;
        if (exmem_en)
            dmem_mask_d = 1'b0;
        else if (hz.dhit && hz.dmem_req_mem && !hz.ihit)
            dmem_mask_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            dmem_mask_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dmem_mask_q <= dmem_mask_d;
        end
    end

    assign hz.pc_en      = pc_en;
    assign hz.ifid_en    = ifid_en;
    assign hz.idex_en    = idex_en;
    assign hz.exmem_en   = exmem_en;
    assign hz.memwb_en   = memwb_en;
    assign hz.ifid_flush = ifid_flush;
    assign hz.idex_flush = idex_flush;
    assign hz.dmem_mask  = dmem_mask_q & ~RST;
    assign hz.halted     = (state_q == HALT) & ~RST;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;
    logic        stall_inc, flush_inc;

    // The halt hand-off cycle also has pc_en=0 but is not a stall.
    assign stall_inc = (state_q == RUN) & ~pc_en & ~(advance & hz.halt_mem);
    assign flush_inc = (state_q == RUN) & advance & ~hz.halt_mem & hz.branch_taken_ex;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + {31'd0, stall_inc};
            flush_cnt_q <= flush_cnt_q + {31'd0, flush_inc};
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: expected control vectors queued per cycle.
module tb_hazard_controller;
    logic CLK = 1'b0;
    logic RST;
    int   total = 0;
    int   bad   = 0;

    hazard_if #(.REGW(5)) hz ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
    hazard_controller #(.REGW(5)) dut (.CLK(CLK), .RST(RST), .hz(hz),
                                       .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
    hazard_controller #(.REGW(5)) dut (.CLK(CLK), .RST(RST), .hz(hz));
`endif

    always #5 CLK = ~CLK;

    // {pc,ifid,idex,exmem,memwb, ifid_fl,idex_fl, mask, halted}
    localparam logic [8:0] E_ZERO = 9'b00000_00_0_0;
    localparam logic [8:0] E_RUN  = 9'b11111_00_0_0;
    localparam logic [8:0] E_LU   = 9'b00111_01_0_0;
    localparam logic [8:0] E_BR   = 9'b11111_11_0_0;
    localparam logic [8:0] E_JMP  = 9'b11111_10_0_0;
    localparam logic [8:0] E_HM   = 9'b00001_00_0_0;
    localparam logic [8:0] E_HLT  = 9'b00000_00_0_1;
    localparam logic [8:0] E_MSK  = 9'b00000_00_1_0;
    localparam logic [8:0] E_MRUN = 9'b11111_00_1_0;

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } sb_t;
    sb_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] obs();
        return {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
                hz.ifid_flush, hz.idex_flush, hz.dmem_mask, hz.halted};
    endfunction

    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            chk(e.tag, {23'd0, obs()}, {23'd0, e.exp});
        end
    end

    // Inputs are already set; queue the expectation and run one cycle.
    task automatic tick(input string tag, input logic [8:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        hz.ihit = 1'b1; hz.dhit = 1'b0; hz.dmem_req_mem = 1'b0; hz.lw_ex = 1'b0;
        hz.wsel_ex = '0; hz.rs_id = '0; hz.rt_id = '0; hz.uses_rt_id = 1'b0;
        hz.branch_taken_ex = 1'b0; hz.jump_id = 1'b0; hz.halt_mem = 1'b0;
    endtask

    task automatic cnt_chk(input string tag, input int st, input int fl);
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, "_stall"}, stall_cnt, st);
        chk({tag, "_flush"}, flush_cnt, fl);
`else
        if (tag.len() < 0) $display("%0d %0d", st, fl);
`endif
    endtask

    initial begin
        @(posedge CLK); #1;
        idle();
        RST = 1'b1;
        tick("rst0", E_ZERO);
        tick("rst1", E_ZERO);
        RST = 1'b0;
        cnt_chk("post_rst", 0, 0);
        repeat (3) tick("run", E_RUN);

        // load-use through rs, one-cycle stall
        hz.lw_ex = 1'b1; hz.wsel_ex = 5'd8; hz.rs_id = 5'd8;
        tick("lu_rs", E_LU);
        idle();
        tick("lu_rs_after", E_RUN);
        cnt_chk("lu_rs", 1, 0);

        // load-use through rt only when rt is a source
        hz.lw_ex = 1'b1; hz.wsel_ex = 5'd9; hz.rs_id = 5'd3; hz.rt_id = 5'd9; hz.uses_rt_id = 1'b1;
        tick("lu_rt", E_LU);
        hz.uses_rt_id = 1'b0;
        tick("lu_rt_unused", E_RUN);
        idle();

        // r0 never creates a hazard
        hz.lw_ex = 1'b1; hz.wsel_ex = 5'd0; hz.rs_id = 5'd0; hz.rt_id = 5'd0; hz.uses_rt_id = 1'b1;
        tick("lu_r0", E_RUN);
        idle();
        cnt_chk("lu_rt", 2, 0);

        // data done while fetch pending: mask holds off reissue
        hz.ihit = 1'b0; hz.dmem_req_mem = 1'b1; hz.dhit = 1'b1;
        tick("dm_f0", E_ZERO);
        tick("dm_f1", E_MSK);
        tick("dm_f2", E_MSK);
        hz.ihit = 1'b1; hz.dhit = 1'b0;
        tick("dm_go", E_MRUN);
        hz.dmem_req_mem = 1'b0;
        tick("dm_clr", E_RUN);
        cnt_chk("dmem", 5, 0);

        // simultaneous ihit & dhit
        hz.dmem_req_mem = 1'b1; hz.dhit = 1'b1;
        tick("both_hit", E_RUN);
        hz.dmem_req_mem = 1'b0; hz.dhit = 1'b0;
        tick("both_after", E_RUN);

        // data miss blocks advance
        hz.dmem_req_mem = 1'b1;
        tick("dmiss", E_ZERO);
        hz.dhit = 1'b1;
        tick("dmiss_done", E_RUN);
        idle();
        cnt_chk("dmiss", 6, 0);

        // branch beats jump
        hz.branch_taken_ex = 1'b1; hz.jump_id = 1'b1;
        tick("br_jmp", E_BR);
        idle();
        tick("br_after", E_RUN);
        cnt_chk("br", 6, 1);
        hz.jump_id = 1'b1;
        tick("jmp", E_JMP);
        idle();

        // branch beats load-use
        hz.branch_taken_ex = 1'b1; hz.lw_ex = 1'b1; hz.wsel_ex = 5'd4; hz.rs_id = 5'd4;
        tick("br_lu", E_BR);
        idle();
        cnt_chk("br_lu", 6, 2);

        // halt: frozen first, then MEM/WB only, drain, halted
        hz.halt_mem = 1'b1; hz.ihit = 1'b0;
        tick("halt_frz", E_ZERO);
        hz.ihit = 1'b1;
        tick("halt_mem", E_HM);
        idle();
        tick("drain", E_ZERO);
        hz.branch_taken_ex = 1'b1;
        tick("halted0", E_HLT);
        tick("halted1", E_HLT);
        idle();
        cnt_chk("halt", 7, 2);
        RST = 1'b1;
        tick("halt_rst", E_ZERO);
        RST = 1'b0;
        tick("rerun", E_RUN);
        cnt_chk("rerun", 0, 0);

        // reset during drain
        hz.halt_mem = 1'b1;
        tick("h2_mem", E_HM);
        idle();
        RST = 1'b1;
        tick("h2_rst", E_ZERO);
        RST = 1'b0;
        tick("h2_run", E_RUN);

        @(negedge CLK);
        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
